// File: rtl/md_unit.sv
// md_unit: iterative-latency multiply/divide unit for the E stage.
// The result is computed in the cycle the command is accepted and held in
// pending registers. HI/LO are updated only when the fixed latency expires,
// so the rest of the pipeline sees the same timing as a real iterative unit.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] MULT_LAT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LAT  = CW'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e        state_q = IDLE;
    state_e        state_d;
    logic [CW-1:0] cnt_q   = '0;
    logic [31:0]   hi_q    = '0;
    logic [31:0]   lo_q    = '0;
    logic [31:0]   p_hi_q  = '0;
    logic [31:0]   p_lo_q  = '0;
    logic          p_wr_q  = 1'b0;   // pending result should be written at commit

    // Arithmetic signals
    logic          md_op, is_div, is_signed;
    logic [63:0]   a_ext, b_ext, prod;
    logic          a_neg, b_neg, div_zero;
    logic [31:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
    logic [31:0]   res_hi, res_lo;
    logic [CW-1:0] lat;

    // Control signals
    logic          accept, commit, hi_we, lo_we;
    logic [31:0]   hi_wdata, lo_wdata;

    // Compute the result of the command on the inputs this cycle.
    always_comb begin
        md_op     = (op[2] == 1'b0);
        is_div    = (op == OP_DIV) || (op == OP_DIVU);
        is_signed = (op == OP_MULT) || (op == OP_DIV);

        // Low 64 bits of the extended product equal the signed or unsigned
        // 32x32 product, depending only on how the operands are extended.
        a_ext = {{32{is_signed & src_a[31]}}, src_a};
        b_ext = {{32{is_signed & src_b[31]}}, src_b};
        prod  = a_ext * b_ext;

        // Sign/magnitude division. 0x80000000 / -1 falls out naturally:
        // magnitude quotient 0x80000000, negated back to 0x80000000, rem 0.
        a_neg    = is_signed & src_a[31];
        b_neg    = is_signed & src_b[31];
        a_mag    = a_neg ? -src_a : src_a;
        b_mag    = b_neg ? -src_b : src_b;
        div_zero = (src_b == 32'd0);
        b_safe   = div_zero ? 32'd1 : b_mag;   // keep the divider well-defined
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        quot     = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem      = a_neg ? -r_mag : r_mag;

        res_hi = is_div ? rem  : prod[63:32];
        res_lo = is_div ? quot : prod[31:0];
        lat    = is_div ? DIV_LAT : MULT_LAT;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: only IDLE accepts work; RUN leaves on the last count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && md_op) state_d = RUN;
            RUN:  if (cnt_q <= CW'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/control decode: accept, commit and MTHI/MTLO write enables.
    always_comb begin
        accept   = 1'b0;
        commit   = 1'b0;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        hi_wdata = p_hi_q;
        lo_wdata = p_lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: accept = 1'b1;
                        OP_MTHI: begin hi_we = 1'b1; hi_wdata = src_a; end
                        OP_MTLO: begin lo_we = 1'b1; lo_wdata = src_a; end
                        default: ;   // reserved encodings are no-ops
                    endcase
                end
            end
            RUN: begin
                if (cnt_q <= CW'(1)) begin
                    commit = 1'b1;
                    hi_we  = p_wr_q;
                    lo_we  = p_wr_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers: pending result, latency counter, HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            p_hi_q <= '0;
            p_lo_q <= '0;
            p_wr_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            if (accept) begin
                cnt_q  <= lat;
                p_hi_q <= res_hi;
                p_lo_q <= res_lo;
                p_wr_q <= !(is_div && div_zero);
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (commit) p_wr_q <= 1'b0;
            if (hi_we)  hi_q <= hi_wdata;
            if (lo_we)  lo_q <= lo_wdata;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: table-driven checks of md_unit plus hand sequences for
// start-while-busy and reset-mid-operation.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one command at the next edge, then count busy cycles (bounded),
    // noting whether HI/LO moved while busy.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int n, output bit held);
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
        n = 0; held = 1'b1;
        while (busy && n < 40) begin
            if (hi !== h0 || lo !== l0) held = 1'b0;
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int  n;
        bit  held;
        bit  quiet;

        vecs[0]  = '{"mthi_11",      3'd4, 32'h11,       32'h0,        32'h11,       32'h0,        0};
        vecs[1]  = '{"mtlo_22",      3'd5, 32'h22,       32'h0,        32'h11,       32'h22,       0};
        vecs[2]  = '{"divu_by_zero", 3'd3, 32'd100,      32'h0,        32'h11,       32'h22,       10};
        vecs[3]  = '{"div_min_m1",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10};
        vecs[4]  = '{"mult_m3x5",    3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        vecs[5]  = '{"multu_max",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[6]  = '{"div_m7_2",     3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[7]  = '{"mthi_dead",    3'd4, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFD, 0};
        vecs[8]  = '{"divu_100_7",   3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       10};
        vecs[9]  = '{"reserved_6",   3'd6, 32'h12345678, 32'h9,        32'd2,        32'd14,       0};
        vecs[10] = '{"mult_min_min", 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        5};
        vecs[11] = '{"div_7_m2",     3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
        vecs[12] = '{"div_m7_m2",    3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        10};
        vecs[13] = '{"div_by_zero",  3'd2, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 32'd3,        10};

        // Reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        // Table: commands issued back-to-back, each on the first idle cycle
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, n, held);
            check({vecs[i].name, "_cycles"}, 32'(n), 32'(vecs[i].cyc));
            check({vecs[i].name, "_hold"}, {31'd0, held}, 32'd1);
            check({vecs[i].name, "_hi"}, hi, vecs[i].hi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].lo);
        end

        // start during RUN (MULT then MTHI) must be ignored
        start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 1)      begin start = 1'b1; op = 3'd0; src_a = 32'd7; src_b = 32'd7; end
            else if (n == 2) begin start = 1'b1; op = 3'd4; src_a = 32'hAAAA; end
            else             start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("ignore_cycles", 32'(n), 32'd5);
        check("ignore_hi", hi, 32'd0);
        check("ignore_lo", lo, 32'd12);

        // Reset on the 4th busy cycle of a DIVU
        issue(3'd4, 32'h55, 32'h0, n, held);
        check("pre_reset_hi", hi, 32'h55);
        start = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("busy_4th_cycle", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        quiet = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (busy || hi !== 32'd0 || lo !== 32'd0) quiet = 1'b0;
        end
        check("no_late_commit", {31'd0, quiet}, 32'd1);
        issue(3'd0, 32'hFFFFFFFD, 32'd5, n, held);
        check("post_rst_cycles", 32'(n), 32'd5);
        check("post_rst_hi", hi, 32'hFFFFFFFF);
        check("post_rst_lo", lo, 32'hFFFFFFF1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
